// File: rtl/conv_mac_engine.sv
// Convolution MAC engine: loads a KxK weight vector and a bias from the weight loader,
// then produces one signed bias + sum(w*p) result per accepted window, one product per cycle.
module conv_mac_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int ACC_WIDTH   = 24
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          load_start,
    output logic                                          sel_bias,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] wl_data,
    output logic                                          weights_ready,
    input  logic                                          pix_valid,
    output logic                                          pix_ready,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pix_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [ACC_WIDTH-1:0]                          out_data
);

    localparam int TAPS   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LW_SET,
        LW_CAP,
        LB_SET,
        LB_CAP,
        READY,
        MAC,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [DATA_WIDTH-1:0] w_reg [TAPS];
    logic signed [DATA_WIDTH-1:0] p_reg [TAPS];
    logic signed [DATA_WIDTH-1:0] bias_reg;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [IDX_W-1:0]             idx;

    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic                         accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A reload request in READY outranks a window arriving in the same cycle.
    always_comb begin
        next_state = state;
        sel_bias   = 1'b0;
        pix_ready  = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start) next_state = LW_SET;
            end
            LW_SET: next_state = LW_CAP;
            LW_CAP: next_state = LB_SET;
            LB_SET: begin
                sel_bias   = 1'b1;
                next_state = LB_CAP;
            end
            LB_CAP: begin
                sel_bias   = 1'b1;
                next_state = READY;
            end
            READY: begin
                pix_ready = 1'b1;
                if (load_start) begin
                    next_state = LW_SET;
                end else if (pix_valid) begin
                    accept     = 1'b1;
                    next_state = MAC;
                end
            end
            MAC: begin
                if (idx == LAST_IDX) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = READY;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        prod     = w_reg[idx] * p_reg[idx];
        prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
        acc_next = acc + prod_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                w_reg[i] <= '0;
                p_reg[i] <= '0;
            end
            bias_reg      <= '0;
            acc           <= '0;
            idx           <= '0;
            out_data      <= '0;
            weights_ready <= 1'b0;
        end else begin
            unique case (state)
                LW_CAP: begin
                    for (int i = 0; i < TAPS; i++) begin
                        w_reg[i] <= wl_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                LB_CAP: begin
                    bias_reg      <= wl_data[DATA_WIDTH-1:0];
                    weights_ready <= 1'b1;
                end
                READY: begin
                    if (load_start) begin
                        weights_ready <= 1'b0;
                    end else if (accept) begin
                        for (int i = 0; i < TAPS; i++) begin
                            p_reg[i] <= pix_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        acc <= {{(ACC_WIDTH-DATA_WIDTH){bias_reg[DATA_WIDTH-1]}}, bias_reg};
                        idx <= '0;
                    end
                end
                MAC: begin
                    // The final tap's sum goes straight to the output register.
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) out_data <= acc_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine: table-driven load/compute vectors with a
// result scoreboard, plus hand-written backpressure, gating, reload and reset sequences.
module tb_conv_mac_engine;

    localparam int DW = 8;
    localparam int K  = 3;
    localparam int KK = K * K;
    localparam int AW = 24;
    localparam int VW = KK * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          sel_bias;
    logic [VW-1:0] wl_data;
    logic          weights_ready;
    logic          pix_valid;
    logic          pix_ready;
    logic [VW-1:0] pix_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;

    logic [VW-1:0] ld_weights;
    logic [DW-1:0] ld_bias;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] sb[$];

    typedef struct {
        logic [VW-1:0] w;
        logic [DW-1:0] b;
        logic [VW-1:0] p;
        logic [AW-1:0] exp;
    } vec_t;

    vec_t tbl[6];

    conv_mac_engine #(
        .DATA_WIDTH (DW),
        .KERNEL_SIZE(K),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .sel_bias     (sel_bias),
        .wl_data      (wl_data),
        .weights_ready(weights_ready),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    // Loader model: upper bits carry weight data even in bias mode, so only the low byte may be used.
    assign wl_data = sel_bias ? {ld_weights[VW-1:DW], ld_bias} : ld_weights;

    function automatic logic [VW-1:0] splat(input logic [DW-1:0] v);
        return {KK{v}};
    endfunction

    function automatic logic [AW-1:0] model(input logic [VW-1:0] w, input logic [DW-1:0] b,
                                            input logic [VW-1:0] p);
        int acc;
        acc = $signed(b);
        for (int i = 0; i < KK; i++) begin
            acc += $signed(w[i*DW +: DW]) * $signed(p[i*DW +: DW]);
        end
        return acc[AW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called one cycle after the edge that sampled load_start.
    task automatic checkLoadSeq();
        for (int i = 0; i < 4; i++) begin
            checkValue("sel_bias_seq", sel_bias, (i >= 2));
            checkValue("weights_ready_during_load", weights_ready, 0);
            checkValue("pix_ready_during_load", pix_ready, 0);
            if (i == 2) ld_weights = ~ld_weights;
            tick();
        end
        checkValue("weights_ready_after_load", weights_ready, 1);
        checkValue("pix_ready_after_load", pix_ready, 1);
    endtask

    task automatic doLoad(input logic [VW-1:0] w, input logic [DW-1:0] b);
        ld_weights = w;
        ld_bias    = b;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checkLoadSeq();
    endtask

    task automatic applyStimulus(input logic [VW-1:0] p, input logic [AW-1:0] exp);
        int n;
        n = 0;
        while (!pix_ready && n < 30) begin
            tick();
            n++;
        end
        checkValue("pix_ready_before_window", pix_ready, 1);
        pix_valid = 1'b1;
        pix_data  = p;
        @(posedge clk);
        sb.push_back(exp);
        #1;
        pix_valid = 1'b0;
        pix_data  = VW'({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic waitResult(input int already);
        int lat;
        lat = already;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        checkValue("result_latency", lat, KK);
    endtask

    task automatic checkOutput(input int hold);
        logic [AW-1:0] exp;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL scoreboard_empty: got out_valid=%0b, required no pending result", out_valid);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            checkValue("hold_out_valid", out_valid, 1);
            checkValue("hold_out_data", out_data, exp);
            checkValue("hold_pix_ready", pix_ready, 0);
            tick();
        end
        checkValue("out_valid", out_valid, 1);
        checkValue("out_data", out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkValue("out_valid_after_handshake", out_valid, 0);
        checkValue("pix_ready_after_handshake", pix_ready, 1);
    endtask

    task automatic checkGated(input int cycles);
        pix_valid = 1'b1;
        pix_data  = splat(8'h11);
        for (int i = 0; i < cycles; i++) begin
            tick();
            checkValue("gated_pix_ready", pix_ready, 0);
            checkValue("gated_out_valid", out_valid, 0);
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [VW-1:0] pw;

        rst        = 1'b1;
        load_start = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = '0;
        out_ready  = 1'b0;
        ld_weights = '0;
        ld_bias    = '0;

        tbl[0] = '{w: splat(8'h01), b: 8'h05, p: splat(8'h02), exp: 24'h000017};
        tbl[1] = '{w: splat(8'hFF), b: 8'h00, p: splat(8'h03), exp: 24'hFFFFE5};
        tbl[2] = '{w: splat(8'h80), b: 8'h7F, p: splat(8'h80), exp: 24'h02407F};
        for (int i = 3; i < 6; i++) begin
            tbl[i].w   = VW'({$urandom(), $urandom(), $urandom()});
            tbl[i].b   = DW'($urandom());
            tbl[i].p   = VW'({$urandom(), $urandom(), $urandom()});
            tbl[i].exp = model(tbl[i].w, tbl[i].b, tbl[i].p);
        end

        tick();
        tick();
        checkValue("reset_sel_bias", sel_bias, 0);
        checkValue("reset_weights_ready", weights_ready, 0);
        checkValue("reset_pix_ready", pix_ready, 0);
        checkValue("reset_out_valid", out_valid, 0);
        checkValue("reset_out_data", out_data, 0);
        rst = 1'b0;
        tick();

        checkGated(12);

        for (int i = 0; i < 6; i++) begin
            doLoad(tbl[i].w, tbl[i].b);
            applyStimulus(tbl[i].p, tbl[i].exp);
            waitResult(0);
            checkOutput((i == 1) ? 5 : 0);
        end

        // Back-to-back window with the last loaded weights.
        pw = VW'({$urandom(), $urandom(), $urandom()});
        applyStimulus(pw, model(tbl[5].w, tbl[5].b, pw));
        waitResult(0);
        checkOutput(0);

        // load_start during MAC must be ignored.
        pw = splat(8'h04);
        applyStimulus(pw, model(tbl[5].w, tbl[5].b, pw));
        tick();
        tick();
        tick();
        ld_weights = splat(8'h07);
        ld_bias    = 8'h33;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checkValue("mac_load_ignored_sel", sel_bias, 0);
        checkValue("mac_load_weights_ready", weights_ready, 1);
        waitResult(4);
        checkOutput(0);

        // Reload and window together in READY: reload wins.
        ld_weights = splat(8'h02);
        ld_bias    = 8'h00;
        load_start = 1'b1;
        pix_valid  = 1'b1;
        pix_data   = splat(8'h09);
        tick();
        load_start = 1'b0;
        pix_valid  = 1'b0;
        checkLoadSeq();
        applyStimulus(splat(8'h01), 24'd18);
        waitResult(0);
        checkOutput(0);

        // Reset while the MAC is at index 4.
        applyStimulus(splat(8'h03), 24'd54);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkValue("midmac_rst_sel_bias", sel_bias, 0);
        checkValue("midmac_rst_weights_ready", weights_ready, 0);
        checkValue("midmac_rst_pix_ready", pix_ready, 0);
        checkValue("midmac_rst_out_valid", out_valid, 0);
        checkValue("midmac_rst_out_data", out_data, 0);
        sb.delete();
        #2;
        rst = 1'b0;
        tick();
        checkGated(12);

        doLoad(splat(8'h01), 8'h05);
        applyStimulus(splat(8'h02), 24'h000017);
        waitResult(0);
        checkOutput(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
